// File: rtl/pixel_arbiter.sv
// Two-client pixel-write arbiter for a VGA plot port: round-robin on ties, lockable bursts.
// Define PIXEL_ARB_BOUNDS_EN to drop accepted pixels outside the 160x120 frame.
module pixel_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic       lock0,
   input  logic       lock1,
   input  logic [7:0] x0,
   input  logic [7:0] x1,
   input  logic [6:0] y0,
   input  logic [6:0] y1,
   input  logic [2:0] color0,
   input  logic [2:0] color1,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] color_out,
   output logic       writeEn,
   output logic       busy
);

   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

   state_e     state_q, state_d;
   logic       ptr_q, ptr_d;  // last client served; reset to 1 so client 0 wins the first tie
   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   logic [2:0] color_q, color_d;
   logic       we_q, we_d;

   logic       grant0, grant1;
   logic       load;
   logic       in_bounds;
   logic [7:0] pix_x;
   logic [6:0] pix_y;
   logic [2:0] pix_color;

   always_comb begin
      grant0  = 1'b0;
      grant1  = 1'b0;
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req0 && req1) begin
               grant0 = ptr_q;
               grant1 = ~ptr_q;
            end else begin
               grant0 = req0;
               grant1 = req1;
            end
            if (grant0 && req0 && lock0) begin
               state_d = StOwn0;
            end else if (grant1 && req1 && lock1) begin
               state_d = StOwn1;
            end
         end
         StOwn0: begin
            grant0 = 1'b1;
            if (!lock0) state_d = StIdle;
         end
         StOwn1: begin
            grant1 = 1'b1;
            if (!lock1) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign ack0 = grant0 & req0 & ~reset;
   assign ack1 = grant1 & req1 & ~reset;
   assign load = ack0 | ack1;

   assign pix_x     = ack1 ? x1 : x0;
   assign pix_y     = ack1 ? y1 : y0;
   assign pix_color = ack1 ? color1 : color0;

`ifdef PIXEL_ARB_BOUNDS_EN
   assign in_bounds = (pix_x <= 8'd159) && (pix_y <= 7'd119);
`else
   assign in_bounds = 1'b1;
`endif

   always_comb begin
      ptr_d   = ptr_q;
      x_d     = x_q;
      y_d     = y_q;
      color_d = color_q;
      we_d    = load & in_bounds;
      if (ack0) ptr_d = 1'b0;
      if (ack1) ptr_d = 1'b1;
      if (load) begin
         x_d     = pix_x;
         y_d     = pix_y;
         color_d = pix_color;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= 1'b1;
         x_q     <= 8'd0;
         y_q     <= 7'd0;
         color_q <= 3'd0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         x_q     <= x_d;
         y_q     <= y_d;
         color_q <= color_d;
         we_q    <= we_d;
      end
   end

   assign x_out     = x_q;
   assign y_out     = y_q;
   assign color_out = color_q;
   assign writeEn   = we_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_pixel_arbiter.sv
// Directed bench for pixel_arbiter: vector table plus burst and mid-burst reset sequences.
module tb_pixel_arbiter;

`ifdef PIXEL_ARB_BOUNDS_EN
   localparam int BE = 1;
`else
   localparam int BE = 0;
`endif

   typedef struct {
      logic       r0, r1, l0, l1;
      logic [7:0] x0;
      logic [6:0] y0;
      logic [2:0] c0;
      logic [7:0] x1;
      logic [6:0] y1;
      logic [2:0] c1;
      logic       a0, a1, we;
      logic [7:0] xo;
      logic [6:0] yo;
      logic [2:0] co;
      logic       bz;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
   logic [7:0] x0 = 0, x1 = 0;
   logic [6:0] y0 = 0, y1 = 0;
   logic [2:0] color0 = 0, color1 = 0;
   logic       ack0, ack1, writeEn, busy;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] color_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pixel_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .lock0     (lock0),
      .lock1     (lock1),
      .x0        (x0),
      .x1        (x1),
      .y0        (y0),
      .y1        (y1),
      .color0    (color0),
      .color1    (color1),
      .ack0      (ack0),
      .ack1      (ack1),
      .x_out     (x_out),
      .y_out     (y_out),
      .color_out (color_out),
      .writeEn   (writeEn),
      .busy      (busy)
   );

   function automatic vec_t mk(input int r0, r1, l0, l1, vx0, vy0, vc0, vx1, vy1, vc1,
                               a0, a1, we, xo, yo, co, bz);
      vec_t v;
      v.r0 = 1'(r0);  v.r1 = 1'(r1);  v.l0 = 1'(l0);  v.l1 = 1'(l1);
      v.x0 = 8'(vx0); v.y0 = 7'(vy0); v.c0 = 3'(vc0);
      v.x1 = 8'(vx1); v.y1 = 7'(vy1); v.c1 = 3'(vc1);
      v.a0 = 1'(a0);  v.a1 = 1'(a1);  v.we = 1'(we);
      v.xo = 8'(xo);  v.yo = 7'(yo);  v.co = 3'(co);  v.bz = 1'(bz);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive on the falling edge, check acks before the rising edge, registered outputs after it.
   task automatic apply_vec(input vec_t v, input string tag);
      @(negedge clk);
      req0 = v.r0; req1 = v.r1; lock0 = v.l0; lock1 = v.l1;
      x0 = v.x0; y0 = v.y0; color0 = v.c0;
      x1 = v.x1; y1 = v.y1; color1 = v.c1;
      #1;
      chk({tag, " ack0"}, 32'(ack0), 32'(v.a0));
      chk({tag, " ack1"}, 32'(ack1), 32'(v.a1));
      @(posedge clk);
      #1;
      chk({tag, " writeEn"}, 32'(writeEn), 32'(v.we));
      chk({tag, " x_out"}, 32'(x_out), 32'(v.xo));
      chk({tag, " y_out"}, 32'(y_out), 32'(v.yo));
      chk({tag, " color_out"}, 32'(color_out), 32'(v.co));
      chk({tag, " busy"}, 32'(busy), 32'(v.bz));
   endtask

   vec_t vecs[19];

   initial begin
      vecs[0]  = mk(1,0,0,0,  50,60,3,   0,0,0,   1,0,1,  50,60,3, 0);
      vecs[1]  = mk(0,0,0,0,  50,60,3,   0,0,0,   0,0,0,  50,60,3, 0);
      vecs[2]  = mk(1,1,0,0,  10,11,1,  20,21,2,  0,1,1,  20,21,2, 0);
      vecs[3]  = mk(1,1,0,0,  10,11,1,  20,21,2,  1,0,1,  10,11,1, 0);
      vecs[4]  = mk(1,1,0,0,  10,11,1,  20,21,2,  0,1,1,  20,21,2, 0);
      vecs[5]  = mk(1,1,0,0,  10,11,1,  20,21,2,  1,0,1,  10,11,1, 0);
      vecs[6]  = mk(1,0,1,0,  30,31,4,  20,21,2,  1,0,1,  30,31,4, 1);
      vecs[7]  = mk(1,1,1,0,  31,32,5,  20,21,2,  1,0,1,  31,32,5, 1);
      vecs[8]  = mk(0,1,1,0,  31,32,5,  20,21,2,  0,0,0,  31,32,5, 1);
      vecs[9]  = mk(1,1,0,0,  32,33,6,  20,21,2,  1,0,1,  32,33,6, 0);
      vecs[10] = mk(1,1,0,1,  32,33,6,  40,41,5,  0,1,1,  40,41,5, 1);
      vecs[11] = mk(1,0,0,1,  32,33,6,  40,41,5,  0,0,0,  40,41,5, 1);
      vecs[12] = mk(1,1,0,1,  32,33,6,  41,42,3,  0,1,1,  41,42,3, 1);
      vecs[13] = mk(0,0,0,0,  32,33,6,  41,42,3,  0,0,0,  41,42,3, 0);
      vecs[14] = mk(1,0,0,0, 158,100,2,   0,0,0,  1,0,1, 158,100,2, 0);
      vecs[15] = mk(1,0,0,0, 160,100,6,   0,0,0,  1,0,1-BE, 160,100,6, 0);
      vecs[16] = mk(1,0,0,0, 159,119,1,   0,0,0,  1,0,1, 159,119,1, 0);
      vecs[17] = mk(1,0,0,0,  10,120,4,   0,0,0,  1,0,1-BE, 10,120,4, 0);
      vecs[18] = mk(0,0,0,0,  10,120,4,   0,0,0,  0,0,0,  10,120,4, 0);

      // Reset state
      #2;
      chk("rst writeEn", 32'(writeEn), 32'd0);
      chk("rst x_out", 32'(x_out), 32'd0);
      chk("rst y_out", 32'(y_out), 32'd0);
      chk("rst color_out", 32'(color_out), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      req0 = 1'b1; req1 = 1'b1;
      #1;
      chk("rst ack0", 32'(ack0), 32'd0);
      chk("rst ack1", 32'(ack1), 32'd0);
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      reset = 1'b0;

      // Ties right after reset alternate starting with client 0
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) apply_vec(mk(1,1,0,0, 1,2,3, 4,5,6, 1,0,1, 1,2,3, 0), "rr");
         else            apply_vec(mk(1,1,0,0, 1,2,3, 4,5,6, 0,1,1, 4,5,6, 0), "rr");
      end

      // 16-pixel locked burst by client 0 while client 1 keeps requesting
      for (int i = 0; i < 16; i++) begin
         apply_vec(mk(1,1,1,0, 100+i,50+i,i%8, 7,8,2, 1,0,1, 100+i,50+i,i%8, 1), "burst0");
      end
      apply_vec(mk(0,1,0,0, 115,65,7, 7,8,2, 0,0,0, 115,65,7, 0), "burst0 end");
      apply_vec(mk(1,1,0,1, 115,65,7, 7,8,2, 0,1,1, 7,8,2, 1), "grant1");
      apply_vec(mk(1,1,0,1, 115,65,7, 9,10,3, 0,1,1, 9,10,3, 1), "own1");

      // Asynchronous reset in the middle of the client 1 burst
      #1;
      reset = 1'b1;
      #1;
      chk("midrst ack1", 32'(ack1), 32'd0);
      chk("midrst writeEn", 32'(writeEn), 32'd0);
      chk("midrst x_out", 32'(x_out), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("midrst held writeEn", 32'(writeEn), 32'd0);
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
      reset = 1'b0;
      apply_vec(mk(0,0,0,0, 5,6,7, 9,10,3, 0,0,0, 0,0,0, 0), "postrst idle");
      apply_vec(mk(1,1,0,0, 5,6,7, 9,10,3, 1,0,1, 5,6,7, 0), "postrst tie");

      for (int i = 0; i < 19; i++) begin
         apply_vec(vecs[i], $sformatf("vec%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
